// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It arbitrates between
// memory wait, load-use stalls and branch mispredict flushes. It also runs a
// memory-wait watchdog and saturating stall/flush/retire counters.
module pipeline_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int WAIT_TIMEOUT    = 256,
  parameter int CNT_W           = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_ID_rs1_addr,
  input  logic [4:0]       i_ID_rs2_addr,
  input  logic             i_ID_rs1_use,
  input  logic             i_ID_rs2_use,
  input  logic [4:0]       i_EX_rd_addr,
  input  logic             i_EX_is_load,
  input  logic             i_EX_rdwren,
  input  logic             i_mispred_EX,
  input  logic             i_mem_wait,
  input  logic             i_insnvld_WB,
  input  logic             i_cnt_clr,
  output logic             o_pc_en,
  output logic             o_en_IF_ID,
  output logic             o_flush_IF_ID,
  output logic             o_en_ID_EX,
  output logic             o_flush_ID_EX,
  output logic             o_en_EX_M,
  output logic             o_flush_M_WB,
  output logic             o_mem_timeout,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LU   = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lu_rem_q, lu_rem_d;
  logic              lu_pend_q, lu_pend_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  stall_q, flush_q, retire_q;
  logic              hazard;
  logic              lu_active;
  logic              flush_fire;

  // Saturating increment: the counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  assign hazard = i_EX_is_load & i_EX_rdwren & (i_EX_rd_addr != 5'd0) &
                  ((i_ID_rs1_use & (i_ID_rs1_addr == i_EX_rd_addr)) |
                   (i_ID_rs2_use & (i_ID_rs2_addr == i_EX_rd_addr)));

  // A load-use stall interrupted by memory wait resumes on the cycle the wait drops.
  assign lu_active = (state_q == S_LU) | ((state_q == S_WAIT) & lu_pend_q);

  // Priority arbitration of control outputs and next-state selection.
  always_comb begin
    o_pc_en       = 1'b1;
    o_en_IF_ID    = 1'b1;
    o_flush_IF_ID = 1'b0;
    o_en_ID_EX    = 1'b1;
    o_flush_ID_EX = 1'b0;
    o_en_EX_M     = 1'b1;
    o_flush_M_WB  = 1'b0;
    flush_fire    = 1'b0;
    state_d       = state_q;
    lu_rem_d      = lu_rem_q;
    lu_pend_d     = lu_pend_q;
    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_en_IF_ID    = 1'b0;
      o_en_ID_EX    = 1'b0;
      o_en_EX_M     = 1'b0;
      o_flush_IF_ID = 1'b1;
      o_flush_ID_EX = 1'b1;
      o_flush_M_WB  = 1'b1;
    end else if (i_mem_wait) begin
      // Freeze everything up to M; the EX instruction re-presents later.
      o_pc_en      = 1'b0;
      o_en_IF_ID   = 1'b0;
      o_en_ID_EX   = 1'b0;
      o_en_EX_M    = 1'b0;
      o_flush_M_WB = 1'b1;
      state_d      = S_WAIT;
      if (state_q == S_LU) lu_pend_d = 1'b1;
    end else if (lu_active) begin
      o_pc_en       = 1'b0;
      o_en_IF_ID    = 1'b0;
      o_flush_ID_EX = 1'b1;
      lu_pend_d     = 1'b0;
      if (lu_rem_q > 2'd1) begin
        state_d  = S_LU;
        lu_rem_d = lu_rem_q - 2'd1;
      end else begin
        state_d  = S_RUN;
        lu_rem_d = 2'd0;
      end
    end else if (i_mispred_EX) begin
      o_flush_IF_ID = 1'b1;
      o_flush_ID_EX = 1'b1;
      flush_fire    = 1'b1;
      state_d       = S_RUN;
    end else if (hazard) begin
      o_pc_en       = 1'b0;
      o_en_IF_ID    = 1'b0;
      o_flush_ID_EX = 1'b1;
      if (LU_STALL_CYCLES == 2) begin
        state_d  = S_LU;
        lu_rem_d = 2'd1;
      end else begin
        state_d  = S_RUN;
      end
    end else begin
      state_d = S_RUN;
    end
  end

  // Watchdog: count consecutive wait cycles, saturating at the timeout.
  always_comb begin
    wcnt_d = '0;
    if (i_mem_wait) wcnt_d = (wcnt_q == WAIT_MAX) ? wcnt_q : wcnt_q + 1'b1;
    tmo_d = tmo_q | (wcnt_d == WAIT_MAX);
  end

  // State, watchdog and performance counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_RUN;
      lu_rem_q  <= 2'd0;
      lu_pend_q <= 1'b0;
      wcnt_q    <= '0;
      tmo_q     <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      lu_rem_q  <= lu_rem_d;
      lu_pend_q <= lu_pend_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      if (i_cnt_clr) begin
        stall_q  <= '0;
        flush_q  <= '0;
        retire_q <= '0;
      end else begin
        stall_q  <= sat_inc(stall_q, ~o_pc_en);
        flush_q  <= sat_inc(flush_q, flush_fire);
        retire_q <= sat_inc(retire_q, i_insnvld_WB);
      end
    end
  end

  assign o_state       = state_q;
  assign o_mem_timeout = tmo_q;
  assign o_stall_cnt   = stall_q;
  assign o_flush_cnt   = flush_q;
  assign o_retire_cnt  = retire_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: instance A uses single-cycle load-use stalls
// and 32-bit counters; instance B uses two-cycle stalls and 4-bit counters.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, ld, wr, misp, mw, wbv, clr;

  logic a_pc, a_ei, a_fi, a_ee, a_fe, a_em, a_fm, a_tmo;
  logic [1:0] a_st;
  logic [31:0] a_sc, a_fc, a_rc;
  logic b_pc, b_ei, b_fi, b_ee, b_fe, b_em, b_fm, b_tmo;
  logic [1:0] b_st;
  logic [3:0] b_sc, b_fc, b_rc;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .WAIT_TIMEOUT(256), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_ID_rs1_addr(rs1), .i_ID_rs2_addr(rs2),
    .i_ID_rs1_use(u1), .i_ID_rs2_use(u2), .i_EX_rd_addr(rd), .i_EX_is_load(ld),
    .i_EX_rdwren(wr), .i_mispred_EX(misp), .i_mem_wait(mw), .i_insnvld_WB(wbv),
    .i_cnt_clr(clr), .o_pc_en(a_pc), .o_en_IF_ID(a_ei), .o_flush_IF_ID(a_fi),
    .o_en_ID_EX(a_ee), .o_flush_ID_EX(a_fe), .o_en_EX_M(a_em), .o_flush_M_WB(a_fm),
    .o_mem_timeout(a_tmo), .o_state(a_st), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc),
    .o_retire_cnt(a_rc));

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(2), .WAIT_TIMEOUT(256), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_ID_rs1_addr(rs1), .i_ID_rs2_addr(rs2),
    .i_ID_rs1_use(u1), .i_ID_rs2_use(u2), .i_EX_rd_addr(rd), .i_EX_is_load(ld),
    .i_EX_rdwren(wr), .i_mispred_EX(misp), .i_mem_wait(mw), .i_insnvld_WB(wbv),
    .i_cnt_clr(clr), .o_pc_en(b_pc), .o_en_IF_ID(b_ei), .o_flush_IF_ID(b_fi),
    .o_en_ID_EX(b_ee), .o_flush_ID_EX(b_fe), .o_en_EX_M(b_em), .o_flush_M_WB(b_fm),
    .o_mem_timeout(b_tmo), .o_state(b_st), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc),
    .o_retire_cnt(b_rc));

  // Control vector order: {pc_en, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX, en_EX_M, flush_M_WB}
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] STL  = 7'b0001110;
  localparam logic [6:0] MISP = 7'b1111110;
  localparam logic [6:0] FRZ  = 7'b0000001;
  localparam logic [6:0] RSTV = 7'b0010101;

  typedef struct {
    string       tag;
    bit          dut;
    logic [6:0]  ctrl;
    logic [1:0]  st;
    bit          cc;
    logic [31:0] s, f, r;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic expect_v(input string tag, input bit d, input logic [6:0] c,
                          input logic [1:0] st, input bit cc, input int s,
                          input int f, input int r, input logic tmo);
    exp_t e;
    e.tag = tag; e.dut = d; e.ctrl = c; e.st = st; e.cc = cc;
    e.s = s; e.f = f; e.r = r; e.tmo = tmo;
    q.push_back(e);
  endtask

  task automatic expect_both(input string tag, input logic [6:0] c, input logic [1:0] st);
    expect_v(tag, 1'b0, c, st, 1'b0, 0, 0, 0, 1'b0);
    expect_v(tag, 1'b1, c, st, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_now(input string tag, input bit ok);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: direct check failed", tag);
  endtask

  // Monitor: compares every queued expectation against the DUT away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [6:0] ac;
      logic [1:0] as;
      logic [31:0] s, f, r;
      logic t;
      bit ok;
      e = q.pop_front();
      if (!e.dut) begin
        ac = {a_pc, a_ei, a_fi, a_ee, a_fe, a_em, a_fm};
        as = a_st; s = a_sc; f = a_fc; r = a_rc; t = a_tmo;
      end else begin
        ac = {b_pc, b_ei, b_fi, b_ee, b_fe, b_em, b_fm};
        as = b_st; s = 32'(b_sc); f = 32'(b_fc); r = 32'(b_rc); t = b_tmo;
      end
      ok = (ac === e.ctrl) && (as === e.st);
      if (e.cc) ok = ok && (s === e.s) && (f === e.f) && (r === e.r) && (t === e.tmo);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s dut%s: got ctrl=%b st=%0d stall=%0d flush=%0d retire=%0d tmo=%b; want ctrl=%b st=%0d stall=%0d flush=%0d retire=%0d tmo=%b (counters checked=%0d)",
                    e.tag, e.dut ? "B" : "A", ac, as, s, f, r, t,
                    e.ctrl, e.st, e.s, e.f, e.r, e.tmo, e.cc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    u1 = 1'b0; u2 = 1'b0; ld = 1'b0; wr = 1'b0;
    misp = 1'b0; mw = 1'b0; wbv = 1'b0; clr = 1'b0;
  endtask

  task automatic set_ex(input logic [4:0] r1, input logic iu1, input logic [4:0] r2,
                        input logic iu2, input logic [4:0] d, input logic il, input logic iw);
    rs1 = r1; u1 = iu1; rs2 = r2; u2 = iu2; rd = d; ld = il; wr = iw;
  endtask

  task automatic clear_counters();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset: all enables low, all flushes high, counters and watchdog zero.
    check_now("reset_direct_a",
              ({a_pc, a_ei, a_fi, a_ee, a_fe, a_em, a_fm} === RSTV) && (a_st === 2'd0) &&
              (a_sc === 32'd0) && (a_fc === 32'd0) && (a_rc === 32'd0) && (a_tmo === 1'b0));
    check_now("reset_direct_b",
              ({b_pc, b_ei, b_fi, b_ee, b_fe, b_em, b_fm} === RSTV) && (b_st === 2'd0) &&
              (b_sc === 4'd0) && (b_fc === 4'd0) && (b_rc === 4'd0) && (b_tmo === 1'b0));
    expect_v("reset", 1'b0, RSTV, 2'd0, 1'b1, 0, 0, 0, 1'b0);
    expect_v("reset", 1'b1, RSTV, 2'd0, 1'b1, 0, 0, 0, 1'b0);
    step();
    rst = 1'b0;
    expect_v("post_reset", 1'b0, NORM, 2'd0, 1'b1, 0, 0, 0, 1'b0);
    expect_v("post_reset", 1'b1, NORM, 2'd0, 1'b1, 0, 0, 0, 1'b0);
    step();

    // Non-hazards: x0 destination, unused rs2, non-writing load.
    set_ex(5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b1);
    expect_both("x0_no_stall", NORM, 2'd0);
    step();
    set_ex(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1);
    expect_both("rs2_unused", NORM, 2'd0);
    step();
    set_ex(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    expect_both("no_rdwren", NORM, 2'd0);
    step();

    // Load x5 in EX, ID reads rs2 = x5.
    set_ex(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    expect_v("lu_hazard", 1'b0, STL, 2'd0, 1'b1, 0, 0, 0, 1'b0);
    expect_v("lu_hazard", 1'b1, STL, 2'd0, 1'b1, 0, 0, 0, 1'b0);
    step();
    idle();
    expect_v("lu_after1", 1'b0, NORM, 2'd0, 1'b1, 1, 0, 0, 1'b0);
    expect_v("lu_after1", 1'b1, STL,  2'd1, 1'b1, 1, 0, 0, 1'b0);
    step();
    expect_v("lu_after2", 1'b0, NORM, 2'd0, 1'b1, 1, 0, 0, 1'b0);
    expect_v("lu_after2", 1'b1, NORM, 2'd0, 1'b1, 2, 0, 0, 1'b0);
    step();
    clear_counters();

    // Mispredict with coincident hazard: flush wins, no stall.
    set_ex(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    misp = 1'b1;
    expect_both("misp_hazard", MISP, 2'd0);
    step();
    idle();
    expect_v("misp_after", 1'b0, NORM, 2'd0, 1'b1, 0, 1, 0, 1'b0);
    expect_v("misp_after", 1'b1, NORM, 2'd0, 1'b1, 0, 1, 0, 1'b0);
    step();
    clear_counters();

    // Memory wait for 3 cycles with mispredict held, then the flush fires.
    mw = 1'b1; misp = 1'b1;
    expect_both("wait_frz1", FRZ, 2'd0);
    step();
    expect_both("wait_frz2", FRZ, 2'd2);
    step();
    expect_both("wait_frz3", FRZ, 2'd2);
    step();
    mw = 1'b0;
    expect_v("wait_misp", 1'b0, MISP, 2'd2, 1'b1, 3, 0, 0, 1'b0);
    expect_v("wait_misp", 1'b1, MISP, 2'd2, 1'b1, 3, 0, 0, 1'b0);
    step();
    misp = 1'b0;
    expect_v("wait_misp_after", 1'b0, NORM, 2'd0, 1'b1, 3, 1, 0, 1'b0);
    expect_v("wait_misp_after", 1'b1, NORM, 2'd0, 1'b1, 3, 1, 0, 1'b0);
    step();
    clear_counters();

    // Memory wait raised during the two-cycle load-use stall.
    set_ex(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    expect_both("lu_wait_hz", STL, 2'd0);
    step();
    idle();
    mw = 1'b1;
    expect_v("lu_wait_w1", 1'b0, FRZ, 2'd0, 1'b0, 0, 0, 0, 1'b0);
    expect_v("lu_wait_w1", 1'b1, FRZ, 2'd1, 1'b0, 0, 0, 0, 1'b0);
    step();
    expect_both("lu_wait_w2", FRZ, 2'd2);
    step();
    mw = 1'b0;
    expect_v("lu_wait_resume", 1'b0, NORM, 2'd2, 1'b0, 0, 0, 0, 1'b0);
    expect_v("lu_wait_resume", 1'b1, STL,  2'd2, 1'b0, 0, 0, 0, 1'b0);
    step();
    expect_v("lu_wait_run", 1'b0, NORM, 2'd0, 1'b1, 3, 0, 0, 1'b0);
    expect_v("lu_wait_run", 1'b1, NORM, 2'd0, 1'b1, 4, 0, 0, 1'b0);
    step();
    clear_counters();

    // Retire saturation on the 4-bit instance, then the 256-cycle watchdog.
    wbv = 1'b1;
    repeat (20) step();
    wbv = 1'b0;
    mw = 1'b1;
    expect_v("retire_sat", 1'b0, FRZ, 2'd0, 1'b1, 0, 0, 20, 1'b0);
    expect_v("retire_sat", 1'b1, FRZ, 2'd0, 1'b1, 0, 0, 15, 1'b0);
    repeat (255) step();
    expect_v("wait_255", 1'b0, FRZ, 2'd2, 1'b1, 255, 0, 20, 1'b0);
    expect_v("wait_255", 1'b1, FRZ, 2'd2, 1'b1, 15, 0, 15, 1'b0);
    step();
    mw = 1'b0;
    check_now("timeout_direct", (a_tmo === 1'b1) && (b_tmo === 1'b1));
    expect_v("timeout_set", 1'b0, NORM, 2'd2, 1'b1, 256, 0, 20, 1'b1);
    expect_v("timeout_set", 1'b1, NORM, 2'd2, 1'b1, 15, 0, 15, 1'b1);
    step();
    check_now("timeout_sticky_direct", (a_tmo === 1'b1) && (b_tmo === 1'b1));
    expect_v("timeout_sticky", 1'b0, NORM, 2'd0, 1'b1, 256, 0, 20, 1'b1);
    expect_v("timeout_sticky", 1'b1, NORM, 2'd0, 1'b1, 15, 0, 15, 1'b1);
    step();
    clr = 1'b1; wbv = 1'b1;
    step();
    clr = 1'b0; wbv = 1'b0;
    expect_v("clr_beats_inc", 1'b0, NORM, 2'd0, 1'b1, 0, 0, 0, 1'b1);
    expect_v("clr_beats_inc", 1'b1, NORM, 2'd0, 1'b1, 0, 0, 0, 1'b1);
    step();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline with two-bit dynamic branch prediction. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/M and M/WB pipeline registers from three sources: load-use hazards, EX-stage branch mispredicts and data-memory wait. It also keeps a memory-wait timeout watchdog and saturating performance counters for stalls, flushes and retired instructions.

Parameters:
LU_STALL_CYCLES, 1, load-use bubbles inserted per hazard; legal values 1 (M->EX forwarding present) or 2 (no forwarding).
WAIT_TIMEOUT, 256, consecutive i_mem_wait cycles after which o_mem_timeout sets.
CNT_W, 32, width of each performance counter.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_ID_rs1_addr  in  5  ID-stage source register 1
i_ID_rs2_addr  in  5  ID-stage source register 2
i_ID_rs1_use  in  1  ID instruction reads rs1
i_ID_rs2_use  in  1  ID instruction reads rs2
i_EX_rd_addr  in  5  EX-stage destination register
i_EX_is_load  in  1  EX instruction is a load
i_EX_rdwren  in  1  EX instruction writes rd
i_mispred_EX  in  1  EX branch/jump resolved as mispredicted
i_mem_wait  in  1  data memory not ready; M stage must hold
i_insnvld_WB  in  1  valid instruction retiring in WB
i_cnt_clr  in  1  synchronous clear of all counters
o_pc_en  out  1  PC update enable
o_en_IF_ID  out  1  IF/ID capture enable
o_flush_IF_ID  out  1  IF/ID loads a bubble
o_en_ID_EX  out  1  ID/EX capture enable
o_flush_ID_EX  out  1  ID/EX loads a bubble
o_en_EX_M  out  1  EX/M capture enable
o_flush_M_WB  out  1  M/WB loads a bubble; M/WB is always enabled
o_mem_timeout  out  1  sticky watchdog error
o_state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT
o_stall_cnt  out  CNT_W  cycles with o_pc_en = 0
o_flush_cnt  out  CNT_W  mispredict flushes taken
o_retire_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (i_rst high, async): state RUN, all counters 0, o_mem_timeout 0, internal wait counter 0, lu_remaining 0, lu_pending 0.
- While i_rst is high, all enables are 0 and all flushes are 1.
- Control outputs are combinational from the current state and inputs. State and counters update on the rising edge of i_clk.
- hazard = i_EX_is_load & i_EX_rdwren & (i_EX_rd_addr != 0) & ((i_ID_rs1_use & rs1 == rd) | (i_ID_rs2_use & rs2 == rd)).
- Per-cycle priority:
  1. i_mem_wait = 1 (any state): freeze. PC/IF_ID/ID_EX/EX_M enables 0, o_flush_M_WB = 1, no other flushes. The mispredict and hazard inputs are ignored; the EX instruction is held, so it re-presents later.
  2. Else state LU_STALL: o_pc_en = 0, o_en_IF_ID = 0, o_flush_ID_EX = 1. The EX/M and ID/EX enables are 1.
  3. Else i_mispred_EX = 1: o_flush_IF_ID = 1 and o_flush_ID_EX = 1. All enables are 1 so the PC takes the redirect target.
  4. Else hazard = 1: o_pc_en = 0, o_en_IF_ID = 0, o_flush_ID_EX = 1. If LU_STALL_CYCLES = 2, go to LU_STALL with lu_remaining = 1.
  5. Else all enables are 1 and all flushes are 0.
- FSM:
  - RUN -> MEM_WAIT when i_mem_wait = 1.
  - RUN -> LU_STALL per rule 4.
  - LU_STALL -> RUN after lu_remaining cycles.
  - LU_STALL -> MEM_WAIT when i_mem_wait = 1. Set lu_pending; the countdown is paused.
  - MEM_WAIT -> LU_STALL when i_mem_wait falls and lu_pending = 1. The cycle i_mem_wait falls is evaluated as LU_STALL outputs.
  - MEM_WAIT -> RUN when i_mem_wait falls and lu_pending = 0.
- Watchdog:
  - The wait counter increments each cycle i_mem_wait = 1 and is cleared when i_mem_wait = 0. It saturates at WAIT_TIMEOUT.
  - o_mem_timeout sets when the counter reaches WAIT_TIMEOUT. It clears only on reset.
- Counters:
  - o_stall_cnt increments when o_pc_en = 0.
  - o_flush_cnt increments when rule 3 fires.
  - o_retire_cnt increments when i_insnvld_WB = 1.
  - Each counter saturates at all-ones, with no wrap.
  - i_cnt_clr zeroes all three next cycle and beats a same-cycle increment.
- Hazard against x0 never stalls. Mispredict and hazard in the same cycle: mispredict wins, no stall.

Test Plan:
1. Load x5 in EX, ID uses rs2 = x5, LU_STALL_CYCLES = 1 -> one cycle with o_pc_en = 0, o_en_IF_ID = 0, o_flush_ID_EX = 1; o_stall_cnt = 1; then normal.
2. Same stimulus with LU_STALL_CYCLES = 2 -> two stall cycles; o_state sequence 0, 1, 0; o_stall_cnt = 2.
3. i_mispred_EX pulse with a coincident hazard -> o_flush_IF_ID = 1, o_flush_ID_EX = 1, o_pc_en = 1, o_flush_cnt = 1, no stall.
4. i_mem_wait high 3 cycles with i_mispred_EX held -> 3 freeze cycles with o_flush_M_WB = 1 and o_flush_cnt unchanged; on the 4th cycle the flush fires and o_flush_cnt = 1.
5. LU_STALL_CYCLES = 2, i_mem_wait raised during LU_STALL for 2 cycles -> after wait, one further LU_STALL cycle, then RUN.
6. i_mem_wait held 256 cycles -> o_mem_timeout = 1 and stays 1 after wait drops. Counters at all-ones hold. i_cnt_clr -> all 0.
